// File: rtl/floo_simple_rob_ctrl.sv
// Initiator-side ordering guard for SimpleRoB: a request passes only while all in-flight requests
// with its ID target the same destination. Optional stall counter via FLOO_SIMPLE_ROB_STATS_EN.
module floo_simple_rob_ctrl #(
    parameter int unsigned NumIds         = 4,
    parameter int unsigned DstWidth       = 6,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned IdWidth       = (NumIds > 1) ? $clog2(NumIds) : 1,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [IdWidth-1:0]  req_id_i,
    input  logic [DstWidth-1:0] req_dst_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    input  logic                rsp_valid_i,
    input  logic                rsp_ready_i,
    input  logic                rsp_last_i,
    input  logic [IdWidth-1:0]  rsp_id_i,
`ifdef FLOO_SIMPLE_ROB_STATS_EN
    output logic [31:0]         stall_cnt_o,
`endif
    output logic [NumIds-1:0]   busy_o,
    output logic                err_o
);

    logic [NumIds-1:0][CntWidth-1:0] cnt_all;
    logic [NumIds-1:0][DstWidth-1:0] dst_all;
    logic                            allow;
    logic                            issue;
    logic                            retire;
    logic                            err_d, err_q;

    // Only registered state feeds allow, so responses never combinationally gate requests.
    assign allow = (cnt_all[req_id_i] == '0) ||
                   ((dst_all[req_id_i] == req_dst_i) &&
                    (cnt_all[req_id_i] < CntWidth'(MaxOutstanding)));

    assign req_valid_o = req_valid_i & allow;
    assign req_ready_o = req_ready_i & allow;
    assign issue       = req_valid_i & req_ready_i & allow;
    assign retire      = rsp_valid_i & rsp_ready_i & rsp_last_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumIds; gi++) begin : g_id
            logic [CntWidth-1:0] cnt_q, cnt_d;
            logic [DstWidth-1:0] dst_q, dst_d;
            logic                inc, dec;

            assign inc = issue  && (req_id_i == IdWidth'(gi));
            assign dec = retire && (rsp_id_i == IdWidth'(gi));

            // Issue and retire on the same ID cancel out; retire on an idle ID saturates at zero.
            always_comb begin
                cnt_d = cnt_q;
                dst_d = dst_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_q == '0) begin
                        dst_d = req_dst_i;
                    end
                end else if (dec && !inc && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                    dst_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    dst_q <= dst_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
            assign dst_all[gi] = dst_q;
            assign busy_o[gi]  = (cnt_q != '0);
        end
    endgenerate

    assign err_d = retire && (cnt_all[rsp_id_i] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef FLOO_SIMPLE_ROB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (req_valid_i && !allow) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_floo_simple_rob_ctrl.sv
// Bench for floo_simple_rob_ctrl: directed vector table, corner sequences and a random phase,
// all checked against a queue-of-destinations model of the in-flight requests per ID.
module tb_floo_simple_rob_ctrl;

    localparam int NumIds = 4;
    localparam int DstW   = 6;
    localparam int MaxOut = 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            req_valid_i, req_ready_i, req_ready_o, req_valid_o;
    logic [1:0]      req_id_i, rsp_id_i;
    logic [DstW-1:0] req_dst_i;
    logic            rsp_valid_i, rsp_ready_i, rsp_last_i;
    logic [3:0]      busy_o;
    logic            err_o;
`ifdef FLOO_SIMPLE_ROB_STATS_EN
    logic [31:0]     stall_cnt_o;
`endif

    always #5 clk = ~clk;

    floo_simple_rob_ctrl #(.NumIds(NumIds), .DstWidth(DstW), .MaxOutstanding(MaxOut)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_id_i(req_id_i), .req_dst_i(req_dst_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i),
        .rsp_last_i(rsp_last_i), .rsp_id_i(rsp_id_i),
`ifdef FLOO_SIMPLE_ROB_STATS_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .busy_o(busy_o), .err_o(err_o)
    );

    // Reference model: each ID holds the list of destinations of its in-flight requests.
    int          q_dst [NumIds][$];
    bit          err_m;
    int unsigned stall_m;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic       rv, rr;
        logic [1:0] id;
        logic [5:0] dst;
        logic       sv, sr, sl;
        logic [1:0] sid;
        logic       e_vo, e_ro;
        logic [3:0] e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_allow(input int id, input int dst);
        return (q_dst[id].size() == 0) || ((q_dst[id][0] == dst) && (q_dst[id].size() < MaxOut));
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int i = 0; i < NumIds; i++) b[i] = (q_dst[i].size() != 0);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NumIds; i++) q_dst[i].delete();
        err_m   = 0;
        stall_m = 0;
    endtask

    // One clock: drive at posedge+1, check combinational outputs at negedge, check err_o after the edge.
    task automatic cycle(input logic rv, input logic rr, input logic [1:0] id, input logic [5:0] dst,
                         input logic sv, input logic sr, input logic sl, input logic [1:0] sid,
                         output logic g_vo, output logic g_ro, output logic [3:0] g_busy,
                         output logic g_err);
        bit a, iss, ret;
        req_valid_i = rv; req_ready_i = rr; req_id_i = id; req_dst_i = dst;
        rsp_valid_i = sv; rsp_ready_i = sr; rsp_last_i = sl; rsp_id_i = sid;
        @(negedge clk);
        a = m_allow(int'(id), int'(dst));
        g_vo = req_valid_o; g_ro = req_ready_o; g_busy = busy_o;
        check("req_valid_o", 32'(req_valid_o), 32'(rv & a));
        check("req_ready_o", 32'(req_ready_o), 32'(rr & a));
        check("busy_o", 32'(busy_o), 32'(m_busy()));
`ifdef FLOO_SIMPLE_ROB_STATS_EN
        check("stall_cnt_o", stall_cnt_o, stall_m);
`endif
        iss = rv & rr & a;
        ret = sv & sr & sl;
        @(posedge clk);
        #1;
        err_m = 0;
        if (iss && ret && id == sid) begin
            if (q_dst[id].size() == 0) err_m = 1;
        end else begin
            if (iss) q_dst[id].push_back(int'(dst));
            if (ret) begin
                if (q_dst[sid].size() == 0) err_m = 1;
                else void'(q_dst[sid].pop_front());
            end
        end
        if (rv && !a) stall_m++;
        g_err = err_o;
        check("err_o", 32'(err_o), 32'(err_m));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid_i = 0; req_ready_i = 0; req_id_i = 0; req_dst_i = 0;
        rsp_valid_i = 0; rsp_ready_i = 0; rsp_last_i = 0; rsp_id_i = 0;
        m_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    logic       vo, ro, er;
    logic [3:0] bz;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd1, 6'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd1, 6'd7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'd1, 6'd7, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 6'd7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0010, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 6'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'd0, 6'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 6'd2, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0011, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 2'd1, 6'd7, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0011, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0};

        do_reset();
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset err_o", 32'(err_o), 32'd0);
`ifdef FLOO_SIMPLE_ROB_STATS_EN
        check("reset stall_cnt_o", stall_cnt_o, 32'd0);
`endif

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rv, tbl[i].rr, tbl[i].id, tbl[i].dst,
                  tbl[i].sv, tbl[i].sr, tbl[i].sl, tbl[i].sid, vo, ro, bz, er);
            check($sformatf("tbl%0d vo", i), 32'(vo), 32'(tbl[i].e_vo));
            check($sformatf("tbl%0d ro", i), 32'(ro), 32'(tbl[i].e_ro));
            check($sformatf("tbl%0d busy", i), 32'(bz), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d err", i), 32'(er), 32'(tbl[i].e_err));
        end

        // Outstanding limit on id2: the 9th request stays blocked through the retire cycle.
        do_reset();
        for (int i = 0; i < MaxOut; i++) begin
            cycle(1, 1, 2'd2, 6'd3, 0, 0, 0, 2'd0, vo, ro, bz, er);
            check("fill id2 vo", 32'(vo), 32'd1);
        end
        cycle(1, 1, 2'd2, 6'd3, 0, 0, 0, 2'd0, vo, ro, bz, er);
        check("ninth blocked", 32'(vo), 32'd0);
        cycle(1, 1, 2'd2, 6'd3, 1, 1, 1, 2'd2, vo, ro, bz, er);
        check("ninth blocked on retire", 32'(ro), 32'd0);
        cycle(1, 1, 2'd2, 6'd3, 0, 0, 0, 2'd0, vo, ro, bz, er);
        check("ninth passes after retire", 32'(ro), 32'd1);

        // Asynchronous reset in the middle of traffic on all IDs.
        do_reset();
        for (int i = 0; i < NumIds; i++) cycle(1, 1, 2'(i), 6'd1, 0, 0, 0, 2'd0, vo, ro, bz, er);
        check("all busy", 32'(busy_o), 32'hF);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async reset busy_o", 32'(busy_o), 32'd0);
        check("async reset err_o", 32'(err_o), 32'd0);
        m_clear();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cycle(0, 0, 2'd0, 6'd0, 1, 1, 1, 2'd1, vo, ro, bz, er);
        check("late rsp after reset err", 32'(er), 32'd1);

`ifdef FLOO_SIMPLE_ROB_STATS_EN
        do_reset();
        cycle(1, 1, 2'd1, 6'd5, 0, 0, 0, 2'd0, vo, ro, bz, er);
        for (int i = 0; i < 10; i++) cycle(1, 1, 2'd1, 6'd9, 0, 0, 0, 2'd0, vo, ro, bz, er);
        req_valid_i = 0;
        check("stall count 10", stall_cnt_o, 32'd10);
`endif

        // Random traffic over a narrow destination set so conflicts and limits are frequent.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle(1'(($urandom % 4) != 0), 1'($urandom), 2'($urandom), 6'($urandom % 2),
                  1'(($urandom % 3) == 0), 1'($urandom), 1'(($urandom % 4) != 0), 2'($urandom),
                  vo, ro, bz, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
